// File: rtl/hs_burst_master_pkg.sv
// hs_pkg: shared state encoding and direction constants for hs_burst_master
package hs_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, WAIT_ACK, WAIT_REL, ABORT} state_t;
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;
endpackage

// File: rtl/hs_burst_master_sync2.sv
// sync2: two-flop synchroniser with selectable reset level
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1_q, s2_q;
  // plain shift chain, no logic between stages
  always_ff @(posedge clk or posedge rst)
    if (rst) {s2_q, s1_q} <= {2{RST_VAL}};
    else     {s2_q, s1_q} <= {s1_q, d};
  assign q = s2_q;
endmodule

// File: rtl/hs_burst_master.sv
// hs_burst_master: four-phase req/ack burst master with synchronised ack and per-phase timeout
module hs_burst_master
  import hs_pkg::*;
#(
  parameter int DW      = 8,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rw_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic [DW-1:0]    wdata_in,
  output logic             wdata_rd,
  input  logic             ack,
  input  logic [DW-1:0]    bus_in,
  output logic             req,
  output logic             rw,
  output logic [DW-1:0]    bus_out,
  output logic             bus_oe,
  output logic [DW-1:0]    rcvd_data,
  output logic             rcvd_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  state_t state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, beat_q, beat_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic req_q, req_d, rw_q, rw_d, err_q, err_d, done_q, done_d, rv_q, rv_d;
  logic [DW-1:0] bus_out_q, bus_out_d, rdata_q, rdata_d;
  logic ack_s;

  sync2 #(.RST_VAL(1'b0)) u_sync (.clk(clk), .rst(rst), .d(ack), .q(ack_s));

  // state and datapath registers; async reset drops req/bus_oe without a clock
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      beat_q    <= '0;
      tmr_q     <= '0;
      req_q     <= 1'b0;
      rw_q      <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      rv_q      <= 1'b0;
      bus_out_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      tmr_q     <= tmr_d;
      req_q     <= req_d;
      rw_q      <= rw_d;
      err_q     <= err_d;
      done_q    <= done_d;
      rv_q      <= rv_d;
      bus_out_q <= bus_out_d;
      rdata_q   <= rdata_d;
    end

  // handshake sequencing: next state, timer, beat count and data capture
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    beat_d    = beat_q;
    tmr_d     = tmr_q;
    req_d     = req_q;
    rw_d      = rw_q;
    err_d     = err_q;
    done_d    = 1'b0;
    rv_d      = 1'b0;
    bus_out_d = bus_out_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE:
        if (start) begin
          state_d   = SETUP;
          rw_d      = rw_in;
          len_d     = len_in;
          beat_d    = '0;
          err_d     = 1'b0;
          bus_out_d = (rw_in == RW_WRITE) ? wdata_in : bus_out_q;
        end
      SETUP: begin
        req_d   = 1'b1;
        tmr_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK:
        if (ack_s) begin
          req_d   = 1'b0;
          tmr_d   = '0;
          state_d = WAIT_REL;
          rdata_d = (rw_q == RW_READ) ? bus_in : rdata_q;
          rv_d    = (rw_q == RW_READ);
        end else if (tmr_q == TMAX) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ABORT;
        end else tmr_d = tmr_q + TW'(1);
      WAIT_REL:
        if (!ack_s) begin
          if (beat_q == len_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            beat_d    = beat_q + LEN_W'(1);
            state_d   = SETUP;
            bus_out_d = (rw_q == RW_WRITE) ? wdata_in : bus_out_q;
          end
        end else if (tmr_q == TMAX) begin
          err_d   = 1'b1;
          state_d = ABORT;
        end else tmr_d = tmr_q + TW'(1);
      ABORT: begin
        req_d = 1'b0;
        if (!ack_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req        = req_q;
  assign rw         = rw_q;
  assign bus_out    = bus_out_q;
  assign bus_oe     = (rw_q == RW_WRITE) && (state_q inside {SETUP, WAIT_ACK, WAIT_REL});
  assign wdata_rd   = (rw_q == RW_WRITE) && (state_q == SETUP);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign rcvd_data  = rdata_q;
  assign rcvd_valid = rv_q;
endmodule

// File: tb/tb_hs_burst_master.sv
// tb_hs_burst_master: scenario tasks plus a read/write data scoreboard for hs_burst_master
module tb_hs_burst_master;
  localparam int DW = 8;
  localparam int LW = 4;
  localparam int TO = 15;
  localparam int M_LOOP = 0, M_SILENT = 1, M_HOLD = 2;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, rw_in = 1'b0;
  logic [LW-1:0] len_in = '0;
  logic [DW-1:0] wdata_in = '0, bus_in = '0;
  logic ack, wdata_rd, req, rw, bus_oe, rcvd_valid, busy, done, err;
  logic [DW-1:0] bus_out, rcvd_data;

  int chk = 0, pass = 0, cyc = 0, mode = M_LOOP, hold_cnt = 0;
  logic ack_hold = 1'b0, mon_prev = 1'b0;
  logic [DW-1:0] rd_src[$], rd_exp[$], wr_src[$], wr_exp[$];
  int v_cyc[$];

  hs_burst_master #(.DW(DW), .LEN_W(LW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .rw_in(rw_in), .len_in(len_in),
    .wdata_in(wdata_in), .wdata_rd(wdata_rd), .ack(ack), .bus_in(bus_in),
    .req(req), .rw(rw), .bus_out(bus_out), .bus_oe(bus_oe),
    .rcvd_data(rcvd_data), .rcvd_valid(rcvd_valid), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ack = (mode == M_LOOP) ? req : (mode == M_HOLD) ? ack_hold : 1'b0;

  // slave that keeps ack asserted for 30 cycles after req drops
  always @(negedge clk)
    if (mode == M_HOLD) begin
      if (req) begin ack_hold = 1'b1; hold_cnt = 30; end
      else if (hold_cnt > 0) hold_cnt = hold_cnt - 1;
      else ack_hold = 1'b0;
    end

  // scoreboard: read words on rcvd_valid, write words as the slave sees req rise
  always @(negedge clk) begin
    if (rcvd_valid) begin
      chk++;
      if (rd_exp.size() == 0) $display("FAIL rd_sb unexpected rcvd_valid data=%h", rcvd_data);
      else begin
        logic [DW-1:0] e;
        e = rd_exp.pop_front();
        if (rcvd_data !== e) $display("FAIL rd_sb got %h want %h", rcvd_data, e);
        else pass++;
      end
    end
    if (req && !mon_prev && bus_oe) begin
      chk++;
      if (wr_exp.size() == 0) $display("FAIL wr_sb unexpected write data=%h", bus_out);
      else begin
        logic [DW-1:0] e;
        e = wr_exp.pop_front();
        if (bus_out !== e) $display("FAIL wr_sb got %h want %h", bus_out, e);
        else pass++;
      end
    end
    mon_prev = req;
  end

  // acts as command source and slave data side until done or the cycle budget runs out
  task automatic observe(input int max, output int e, output int fall, output int dn,
                         output int nwrd, output int nreq, output int noe,
                         output logic err_at, output logic busy_at);
    logic p;
    p = req; e = -1; fall = -1; dn = -1; nwrd = 0; nreq = 0; noe = 0;
    err_at = 1'bx; busy_at = 1'bx;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (req && !p) begin
        nreq++;
        if (e < 0) e = cyc;
        if (!rw && rd_src.size() > 0) bus_in = rd_src.pop_front();
      end
      if (!req && p && fall < 0) fall = cyc;
      p = req;
      if (wdata_rd) begin
        nwrd++;
        if (wr_src.size() > 0) begin wdata_in = wr_src.pop_front(); wr_exp.push_back(wdata_in); end
      end
      if (rcvd_valid) v_cyc.push_back(cyc);
      if (bus_oe) noe++;
      if (done) begin dn = cyc; err_at = err; busy_at = busy; break; end
    end
  endtask

  task automatic launch(input logic r, input logic [LW-1:0] l);
    @(negedge clk);
    rw_in = r; len_in = l; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    chk++; if ({req, busy, done, err, bus_oe, wdata_rd, rcvd_valid, rw} !== 8'h00)
      $display("FAIL reset_ctrl got %b want 00000000", {req, busy, done, err, bus_oe, wdata_rd, rcvd_valid, rw}); else pass++;
    chk++; if ({bus_out, rcvd_data} !== '0) $display("FAIL reset_data got %h want 0", {bus_out, rcvd_data}); else pass++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk++; if (busy !== 1'b0) $display("FAIL reset_idle busy got %b want 0", busy); else pass++;
  endtask

  task automatic test_single_write();
    int e, f, dn, nw, nr, no; logic ea, ba;
    mode = M_LOOP;
    wdata_in = 8'hA5; wr_exp.push_back(8'hA5);
    launch(1'b1, '0);
    observe(60, e, f, dn, nw, nr, no, ea, ba);
    chk++; if (dn - e !== 6) $display("FAIL wr_done_lat got %0d want 6", dn - e); else pass++;
    chk++; if (f - e !== 3) $display("FAIL wr_req_fall got %0d want 3", f - e); else pass++;
    chk++; if (nw !== 1) $display("FAIL wr_pops got %0d want 1", nw); else pass++;
    chk++; if (ea !== 1'b0) $display("FAIL wr_err got %b want 0", ea); else pass++;
    chk++; if (wr_exp.size() !== 0) $display("FAIL wr_pending got %0d want 0", wr_exp.size()); else pass++;
  endtask

  task automatic test_read_burst();
    int e, f, dn, nw, nr, no; logic ea, ba;
    logic [DW-1:0] vals[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    mode = M_LOOP;
    v_cyc.delete();
    foreach (vals[i]) begin rd_src.push_back(vals[i]); rd_exp.push_back(vals[i]); end
    launch(1'b0, 4'd3);
    observe(120, e, f, dn, nw, nr, no, ea, ba);
    chk++; if (v_cyc.size() !== 4) $display("FAIL rd_valid_cnt got %0d want 4", v_cyc.size()); else pass++;
    for (int i = 1; i < 4; i++) begin
      chk++;
      if (i >= v_cyc.size()) $display("FAIL rd_spacing beat %0d missing", i);
      else if (v_cyc[i] - v_cyc[i-1] !== 7) $display("FAIL rd_spacing got %0d want 7", v_cyc[i] - v_cyc[i-1]);
      else pass++;
    end
    chk++; if (dn - e !== 27) $display("FAIL rd_done_lat got %0d want 27", dn - e); else pass++;
    chk++; if (nr !== 4) $display("FAIL rd_req_cnt got %0d want 4", nr); else pass++;
    chk++; if (no !== 0) $display("FAIL rd_bus_oe got %0d want 0", no); else pass++;
    chk++; if (rd_exp.size() !== 0) $display("FAIL rd_pending got %0d want 0", rd_exp.size()); else pass++;
  endtask

  task automatic test_silent_timeout();
    int e, f, dn, nw, nr, no; logic ea, ba;
    mode = M_SILENT;
    v_cyc.delete();
    launch(1'b0, '0);
    observe(80, e, f, dn, nw, nr, no, ea, ba);
    chk++; if (f - e !== TO + 1) $display("FAIL to_req_fall got %0d want %0d", f - e, TO + 1); else pass++;
    chk++; if (dn - e !== TO + 2) $display("FAIL to_done got %0d want %0d", dn - e, TO + 2); else pass++;
    chk++; if (ea !== 1'b1) $display("FAIL to_err got %b want 1", ea); else pass++;
    chk++; if (ba !== 1'b0) $display("FAIL to_busy got %b want 0", ba); else pass++;
    chk++; if (v_cyc.size() !== 0) $display("FAIL to_valid got %0d want 0", v_cyc.size()); else pass++;
    mode = M_LOOP;
  endtask

  task automatic test_rel_timeout();
    int e, f, dn, nw, nr, no; logic ea, ba;
    mode = M_HOLD;
    rd_src.push_back(8'h77); rd_exp.push_back(8'h77);
    launch(1'b0, '0);
    observe(120, e, f, dn, nw, nr, no, ea, ba);
    chk++; if (dn - e !== 36) $display("FAIL rel_done got %0d want 36", dn - e); else pass++;
    chk++; if (ea !== 1'b1) $display("FAIL rel_err got %b want 1", ea); else pass++;
    mode = M_LOOP;
    rd_src.push_back(8'h78); rd_exp.push_back(8'h78);
    launch(1'b0, '0);
    chk++; if (err !== 1'b0) $display("FAIL rel_err_clear got %b want 0", err); else pass++;
    observe(60, e, f, dn, nw, nr, no, ea, ba);
    chk++; if (dn - e !== 6 || ea !== 1'b0) $display("FAIL rel_next got lat %0d err %b want 6 0", dn - e, ea); else pass++;
  endtask

  task automatic test_async_reset();
    int e, f, dn, nw, nr, no, reqs, dones; logic ea, ba, p;
    mode = M_LOOP;
    wdata_in = 8'h01; wr_exp.push_back(8'h01);
    wr_src.push_back(8'h02); wr_src.push_back(8'h03); wr_src.push_back(8'h04);
    launch(1'b1, 4'd3);
    reqs = 0; p = req;
    for (int i = 0; i < 40 && reqs < 2; i++) begin
      @(negedge clk);
      if (req && !p) reqs++;
      p = req;
      if (wdata_rd && wr_src.size() > 0) begin wdata_in = wr_src.pop_front(); wr_exp.push_back(wdata_in); end
    end
    chk++; if (reqs !== 2) $display("FAIL ar_reach_beat2 got %0d want 2", reqs); else pass++;
    #2 rst = 1'b1;
    #1;
    chk++; if ({req, bus_oe, busy} !== 3'b000) $display("FAIL ar_async got %b want 000", {req, bus_oe, busy}); else pass++;
    @(negedge clk);
    rst = 1'b0;
    wr_src.delete(); wr_exp.delete();
    dones = 0;
    repeat (10) begin @(negedge clk); if (done) dones++; end
    chk++; if (dones !== 0) $display("FAIL ar_no_done got %0d want 0", dones); else pass++;
    rd_src.push_back(8'h5A); rd_exp.push_back(8'h5A);
    launch(1'b0, '0);
    observe(60, e, f, dn, nw, nr, no, ea, ba);
    chk++; if (dn - e !== 6 || ea !== 1'b0) $display("FAIL ar_read_after got lat %0d err %b want 6 0", dn - e, ea); else pass++;
  endtask

  task automatic test_back_to_back();
    int e, f, dn, nw, nr, no, e2, dn2; logic ea, ba;
    mode = M_LOOP;
    rd_src.push_back(8'h31); rd_src.push_back(8'h32);
    rd_exp.push_back(8'h31); rd_exp.push_back(8'h32);
    @(negedge clk);
    rw_in = 1'b0; len_in = '0; start = 1'b1;
    observe(60, e, f, dn, nw, nr, no, ea, ba);
    chk++; if (nr !== 1) $display("FAIL b2b_no_restart got %0d want 1", nr); else pass++;
    chk++; if (dn - e !== 6) $display("FAIL b2b_first_lat got %0d want 6", dn - e); else pass++;
    @(posedge clk);
    #1 start = 1'b0;
    observe(60, e2, f, dn2, nw, nr, no, ea, ba);
    chk++; if (e2 - dn !== 2) $display("FAIL b2b_req_gap got %0d want 2", e2 - dn); else pass++;
    chk++; if (dn2 - e2 !== 6) $display("FAIL b2b_second_lat got %0d want 6", dn2 - e2); else pass++;
    chk++; if (rd_exp.size() !== 0) $display("FAIL b2b_pending got %0d want 0", rd_exp.size()); else pass++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_burst();
    test_silent_timeout();
    test_rel_timeout();
    test_async_reset();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
